// File: rtl/qspi_target.sv
// qspi_target: quad-SPI memory target, oversampled in the clk domain.
// Accepts quad read (EB) and quad write (38) with a 24-bit address into a
// small byte array; any other command is flagged and ignored until deselect.
//
// State    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | deselected, or waiting for a fresh cs_n fall after reset
// S_CMD    | shifting in the 2 command nibbles
// S_ADDR   | shifting in the 6 address nibbles
// S_DUMMY  | counting DUMMY sck rises before read data
// S_RDATA  | driving read nibbles on sck falls
// S_WDATA  | assembling write bytes from sampled nibbles
// S_IGNORE | unsupported command, bus stays tri-stated until deselect
module qspi_target #(
   parameter int MEM_BYTES = 256,
   parameter int DUMMY     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       cs_n,
   input  logic [3:0] sd_in,
   output logic [3:0] sd_out,
   output logic [3:0] sd_oe,
   output logic       busy,
   output logic       cmd_err
);

   localparam int         AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [7:0] CMD_LD   = 8'd1;
   localparam logic [7:0] ADDR_LD  = 8'd5;
   localparam logic [7:0] DUMMY_LD = (DUMMY > 0) ? 8'(DUMMY - 1) : 8'd0;
   localparam logic [7:0] OP_READ  = 8'hEB;
   localparam logic [7:0] OP_WRITE = 8'h38;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
   } state_t;

   state_t      state_q, state_d;
   logic        sck_s1_q, sck_s2_q, sck_s3_q;
   logic        cs_s1_q, cs_s2_q, cs_s3_q;
   logic [3:0]  sd_s1_q, sd_s2_q;
   logic [1:0]  fill_q;
   logic        armed_q, armed_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  nib_q, nib_d;
   logic [23:0] addr_q, addr_d;
   logic        half_q, half_d;
   logic        is_rd_q, is_rd_d;
   logic        oe_q, oe_d;
   logic [3:0]  out_q, out_d;
   logic        err_q, err_d;
   logic        wr_pend_q, wr_pend_d;
   logic [7:0]  wr_byte_q, wr_byte_d;
   logic [7:0]  mem_q [MEM_BYTES];
   logic [AW-1:0] idx;
   logic [7:0]  rd_byte;
   logic        sck_rise, sck_fall, cs_fall;

   // Upper address bits alias onto the array.
   assign idx      = addr_q[AW-1:0];
   assign rd_byte  = mem_q[idx];
   // sck edges only count while selected; a cs_n fall always wins.
   assign sck_rise = ~cs_s2_q &  sck_s2_q & ~sck_s3_q;
   assign sck_fall = ~cs_s2_q & ~sck_s2_q &  sck_s3_q;
   assign cs_fall  =  cs_s3_q & ~cs_s2_q;

   // Input synchronizers plus one extra stage for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_s3_q <= 1'b0;
         cs_s1_q  <= 1'b1;
         cs_s2_q  <= 1'b1;
         cs_s3_q  <= 1'b1;
         sd_s1_q  <= 4'h0;
         sd_s2_q  <= 4'h0;
         fill_q   <= 2'b00;
      end else begin
         sck_s1_q <= sck;
         sck_s2_q <= sck_s1_q;
         sck_s3_q <= sck_s2_q;
         cs_s1_q  <= cs_n;
         cs_s2_q  <= cs_s1_q;
         cs_s3_q  <= cs_s2_q;
         sd_s1_q  <= sd_in;
         sd_s2_q  <= sd_s1_q;
         fill_q   <= {fill_q[0], 1'b1};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and datapath update from synchronized protocol events.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nib_d     = nib_q;
      addr_d    = addr_q;
      half_d    = half_q;
      is_rd_d   = is_rd_q;
      oe_d      = oe_q;
      out_d     = out_q;
      err_d     = 1'b0;
      wr_pend_d = 1'b0;
      wr_byte_d = wr_byte_q;
      // The reset value of the cs_n synchronizer looks like a fall once real
      // samples arrive; only arm after cs_n has truly been seen high.
      armed_d   = armed_q | (fill_q[1] & cs_s2_q);
      if (wr_pend_q) addr_d = addr_q + 24'd1;
      if (cs_s2_q) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         half_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cs_fall && armed_q) begin
                  state_d = S_CMD;
                  cnt_d   = CMD_LD;
                  half_d  = 1'b0;
                  oe_d    = 1'b0;
                  addr_d  = 24'd0;
               end
            end
            S_CMD: begin
               if (sck_rise) begin
                  if (cnt_q == 8'd0) begin
                     case ({nib_q, sd_s2_q})
                        OP_READ: begin
                           is_rd_d = 1'b1;
                           state_d = S_ADDR;
                           cnt_d   = ADDR_LD;
                        end
                        OP_WRITE: begin
                           is_rd_d = 1'b0;
                           state_d = S_ADDR;
                           cnt_d   = ADDR_LD;
                        end
                        default: begin
                           state_d = S_IGNORE;
                           err_d   = 1'b1;
                        end
                     endcase
                  end else begin
                     nib_d = sd_s2_q;
                     cnt_d = cnt_q - 8'd1;
                  end
               end
            end
            S_ADDR: begin
               if (sck_rise) begin
                  addr_d = {addr_q[19:0], sd_s2_q};
                  half_d = 1'b0;
                  if (cnt_q == 8'd0) begin
                     if (!is_rd_q) begin
                        state_d = S_WDATA;
                     end else if (DUMMY == 0) begin
                        state_d = S_RDATA;
                     end else begin
                        state_d = S_DUMMY;
                        cnt_d   = DUMMY_LD;
                     end
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
            end
            S_DUMMY: begin
               if (sck_rise) begin
                  if (cnt_q == 8'd0) state_d = S_RDATA;
                  else               cnt_d   = cnt_q - 8'd1;
               end
            end
            S_RDATA: begin
               if (sck_fall) begin
                  oe_d = 1'b1;
                  if (!half_q) begin
                     out_d  = rd_byte[7:4];
                     half_d = 1'b1;
                  end else begin
                     out_d  = rd_byte[3:0];
                     half_d = 1'b0;
                     addr_d = addr_q + 24'd1;
                  end
               end
            end
            S_WDATA: begin
               if (sck_rise) begin
                  if (!half_q) begin
                     nib_d  = sd_s2_q;
                     half_d = 1'b1;
                  end else begin
                     wr_pend_d = 1'b1;
                     wr_byte_d = {nib_q, sd_s2_q};
                     half_d    = 1'b0;
                  end
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q   <= 1'b0;
         cnt_q     <= 8'd0;
         nib_q     <= 4'h0;
         addr_q    <= 24'd0;
         half_q    <= 1'b0;
         is_rd_q   <= 1'b0;
         oe_q      <= 1'b0;
         out_q     <= 4'h0;
         err_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_byte_q <= 8'h00;
      end else begin
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         nib_q     <= nib_d;
         addr_q    <= addr_d;
         half_q    <= half_d;
         is_rd_q   <= is_rd_d;
         oe_q      <= oe_d;
         out_q     <= out_d;
         err_q     <= err_d;
         wr_pend_q <= wr_pend_d;
         wr_byte_q <= wr_byte_d;
      end
   end

   // Memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_pend_q) mem_q[idx] <= wr_byte_q;
   end

   // Outputs; sd_oe drops combinationally the clk cs_n is seen high.
   always_comb begin
      sd_out  = out_q;
      sd_oe   = (state_q == S_RDATA && oe_q && !cs_s2_q) ? 4'hF : 4'h0;
      busy    = ~cs_s2_q;
      cmd_err = err_q;
   end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: drives QSPI transactions as an initiator and checks
// read data, output enables and error pulses against a byte-array model.
module tb_qspi_target;
   localparam int MEM_BYTES = 256;
   localparam int DUMMY     = 4;
   localparam int HALF      = 6;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       sck   = 1'b0;
   logic       cs_n  = 1'b1;
   logic [3:0] sd_in = 4'h0;
   logic [3:0] sd_out, sd_oe;
   logic       busy, cmd_err;

   int n_cmp = 0;
   int n_err = 0;
   int err_pulses = 0;
   logic [7:0] ref_mem [MEM_BYTES];
   logic [7:0] wr_q [$];

   qspi_target #(.MEM_BYTES(MEM_BYTES), .DUMMY(DUMMY)) dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sd_in(sd_in),
      .sd_out(sd_out), .sd_oe(sd_oe), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   // Count clks with cmd_err high; a proper pulse adds exactly one.
   always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One sck period: present a nibble, sample the bus just before the rise.
   task automatic sck_cycle(input logic [3:0] n, output logic [3:0] o, output logic [3:0] oe);
      sd_in = n;
      wait_clk(HALF);
      o  = sd_out;
      oe = sd_oe;
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
   endtask

   // Full transaction; write bytes come from wr_q, read bytes from ref_mem.
   task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr,
                          input int nbytes, input bit half_byte);
      logic [3:0]  o, oe;
      logic [31:0] hdr;
      logic [7:0]  b;
      int          ma;
      int          err0;
      bit          is_rd, is_wr;
      is_rd = (cmd == 8'hEB);
      is_wr = (cmd == 8'h38);
      err0  = err_pulses;
      hdr   = {cmd, addr};
      cs_n  = 1'b0;
      wait_clk(3);
      for (int k = 0; k < 8; k++) begin
         sck_cycle(hdr[31-4*k -: 4], o, oe);
         check("hdr_oe", 32'(oe), 32'h0);
      end
      if (is_rd) begin
         for (int k = 0; k < DUMMY; k++) begin
            sck_cycle(4'($urandom), o, oe);
            check("dummy_oe", 32'(oe), 32'h0);
         end
         for (int i = 0; i < nbytes; i++) begin
            ma = (int'(addr) + i) % MEM_BYTES;
            sck_cycle(4'($urandom), o, oe);
            check("rd_oe_hi", 32'(oe), 32'hF);
            check("rd_hi", 32'(o), 32'(ref_mem[ma][7:4]));
            sck_cycle(4'($urandom), o, oe);
            check("rd_oe_lo", 32'(oe), 32'hF);
            check("rd_lo", 32'(o), 32'(ref_mem[ma][3:0]));
         end
      end else if (is_wr) begin
         for (int i = 0; i < nbytes; i++) begin
            b = (wr_q.size() > 0) ? wr_q.pop_front() : 8'($urandom);
            sck_cycle(b[7:4], o, oe);
            check("wr_oe", 32'(oe), 32'h0);
            sck_cycle(b[3:0], o, oe);
            check("wr_oe", 32'(oe), 32'h0);
            ref_mem[(int'(addr) + i) % MEM_BYTES] = b;
         end
         if (half_byte) begin
            sck_cycle(4'h7, o, oe);
            check("part_oe", 32'(oe), 32'h0);
         end
      end else begin
         for (int k = 0; k < 6; k++) begin
            sck_cycle(4'($urandom), o, oe);
            check("ign_oe", 32'(oe), 32'h0);
         end
      end
      wait_clk(HALF);
      cs_n = 1'b1;
      wait_clk(2);
      check("desel_oe", 32'(sd_oe), 32'h0);
      check("desel_busy", 32'(busy), 32'h0);
      wait_clk(6);
      check("err_pulses", 32'(err_pulses - err0), (is_rd || is_wr) ? 32'd0 : 32'd1);
   endtask

   initial begin
      logic [3:0]  o, oe;
      logic [31:0] hdr;
      logic [23:0] a, a2;
      int          nb;

      // Reset state
      wait_clk(3);
      check("rst_oe", 32'(sd_oe), 32'h0);
      check("rst_out", 32'(sd_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(cmd_err), 32'h0);
      reset = 1'b0;
      wait_clk(4);

      // Basic write then read back
      wr_q.push_back(8'hA5); wr_q.push_back(8'h3C);
      run_txn(8'h38, 24'h000010, 2, 1'b0);
      run_txn(8'hEB, 24'h000010, 2, 1'b0);

      // Address wrap at the top of the array
      wr_q.push_back(8'h11); wr_q.push_back(8'h22);
      run_txn(8'h38, 24'h0000FF, 2, 1'b0);
      run_txn(8'hEB, 24'h0000FF, 2, 1'b0);
      run_txn(8'hEB, 24'h000000, 1, 1'b0);

      // Unsupported command, then normal operation
      run_txn(8'h9F, 24'h000000, 0, 1'b0);
      run_txn(8'hEB, 24'h000010, 2, 1'b0);

      // Partial write byte is discarded
      wr_q.push_back(8'h5A);
      run_txn(8'h38, 24'h000020, 1, 1'b0);
      run_txn(8'h38, 24'h000020, 0, 1'b1);
      run_txn(8'hEB, 24'h000020, 1, 1'b0);

      // Upper address bits alias
      wr_q.push_back(8'h69);
      run_txn(8'h38, 24'h123456, 1, 1'b0);
      run_txn(8'hEB, 24'h000056, 1, 1'b0);

      // Randomized write/read with aliased read addresses
      for (int it = 0; it < 6; it++) begin
         a  = 24'($urandom);
         nb = $urandom_range(1, 4);
         run_txn(8'h38, a, nb, 1'b0);
         a2 = {16'($urandom), a[7:0]};
         run_txn(8'hEB, a2, nb, 1'b0);
      end

      // Reset in the middle of a read
      wr_q.push_back(8'hC3); wr_q.push_back(8'h96);
      run_txn(8'h38, 24'h000040, 2, 1'b0);
      hdr  = {8'hEB, 24'h000040};
      cs_n = 1'b0;
      wait_clk(3);
      for (int k = 0; k < 8; k++) sck_cycle(hdr[31-4*k -: 4], o, oe);
      for (int k = 0; k < DUMMY; k++) sck_cycle(4'h0, o, oe);
      sck_cycle(4'h0, o, oe);
      check("mid_oe", 32'(oe), 32'hF);
      check("mid_hi", 32'(o), 32'hC);
      wait_clk(2);
      reset = 1'b1;
      #1;
      check("arst_oe", 32'(sd_oe), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(2);
      // cs_n still low: no fresh fall, so the full read must be ignored
      for (int k = 0; k < 8; k++) begin
         sck_cycle(hdr[31-4*k -: 4], o, oe);
         check("norearm_oe", 32'(oe), 32'h0);
      end
      for (int k = 0; k < DUMMY + 2; k++) begin
         sck_cycle(4'h0, o, oe);
         check("norearm_oe", 32'(oe), 32'h0);
      end
      check("held_busy", 32'(busy), 32'h1);
      cs_n = 1'b1;
      wait_clk(6);
      run_txn(8'hEB, 24'h000040, 2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
